sdf_pair_aligner5: RTL
======================

Name: sdf_pair_aligner5

Overview:
- Stage-5 input sequencer of the radix-2 FFT pipeline.
- Accepts a stream of complex float samples and buffers the first half of each 2*D block.
- When the second half streams in, pairs sample n with sample n+D and drives the enable of the stage-5 twiddle-factor provider.
- Emits {x1, x2, tf}, aligned on one valid, to the downstream float butterfly (y1 = x1 + x2*tf, y2 = x1 - x2*tf).

Parameters:
- float_len, 32: bits per float; a complex word is {re, im}, 2*float_len bits, re in the upper half.
- half_len, 16: butterfly span D. Must equal the twiddle provider's tf_num.
- half_addr_len, 4: log2(half_len). Must equal the provider's address width, so both counters wrap together.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- data_in  in  2*float_len  input complex sample.
- data_in_valid  in  1  data_in is valid this cycle. Gaps allowed.
- tf_en  out  1  enable to the twiddle provider. Combinational.
- tf_in  in  2*float_len  twiddle factor from the provider.
- tf_in_valid  in  1  provider's registered valid.
- x1_out  out  2*float_len  buffered first-half sample n.
- x2_out  out  2*float_len  live second-half sample n+D.
- tf_out  out  2*float_len  twiddle W^n captured for this pair.
- pair_valid  out  1  x1/x2/tf outputs are valid.
- align_err  out  1  sticky flag: twiddle and pair stream disagreed.

Behaviour:
- Reset (async, rst=1): cnt=0, s1_valid=0, pair_valid=0, align_err=0, all data outputs 0. Buffer contents are don't-care and are not cleared.
- cnt is half_addr_len+1 bits. It increments only on data_in_valid and wraps 2*D-1 -> 0. Invalid cycles hold all state.
- Phase A (cnt MSB=0):
  - On a valid sample, write buf[cnt low bits] <= data_in.
  - tf_en=0; no output.
- Phase B (cnt MSB=1):
  - tf_en = data_in_valid, combinational, same cycle as the input.
  - On a valid sample, register stage 1: s1_x1 <= buf[cnt low], s1_x2 <= data_in, s1_valid <= 1.
  - Otherwise s1_valid <= 0.
- Provider timing: it latches its address on tf_en and returns tf_in/tf_in_valid one cycle later, i.e. in the cycle where s1_valid=1.
- Stage 2, every clock:
  - x1_out <= s1_x1; x2_out <= s1_x2; tf_out <= tf_in; pair_valid <= s1_valid.
  - Data outputs update only when s1_valid=1.
- Latency: a second-half input at cycle t produces pair_valid=1 at t+2. Throughput is one pair per valid Phase-B cycle.
- Each block of 2*D valid inputs yields exactly D output pairs, with n = 0..D-1 in order.
- align_err: set when s1_valid != tf_in_valid in any cycle. Cleared only by rst.
- Buffer read and write never collide: the read in Phase B uses the same index written D valid samples earlier, and no writes occur in Phase B.
- Back-to-back blocks: Phase A of block k+1 may start the cycle after the last Phase-B sample of block k, with no bubble.
- Reset mid-block discards the partial block. The provider shares rst, so its address restarts at 0 in lockstep with cnt.
- No arithmetic is performed here; float add/multiply lives downstream.

Decomposition:
- Shared FFT package:
  - FLOAT_LEN constant.
  - Complex word width 2*FLOAT_LEN.
  - Per-stage constants HALF_LEN_S5=16 and HALF_ADDR_LEN_S5=4.
  - re/im slice helper.
- Optional sub-module: sdf_half_buffer (D x 2*float_len register array, one write port, one async read port). Everything else stays in the top module.

Test Plan:
- Block feed: 32 continuous valid samples, re=i, im=0, with a stub provider returning tf=n one cycle after tf_en -> 16 pairs (x1=n, x2=n+16, tf=n); first pair_valid 2 cycles after sample 16; tf_en high exactly 16 cycles; align_err=0.
- Gappy input: same 32 samples with valid toggling 1,0,1,0 -> identical 16 pairs in order; pair_valid only 2 cycles after each valid Phase-B input; tf_en never high on an invalid cycle.
- Back-to-back: 64 continuous samples -> 32 pairs; the second block pairs (32+n, 48+n) with tf=n, since the provider's address wrapped.
- Reset mid-block: assert rst after sample 20, then feed a fresh 32 -> outputs immediately 0, pair_valid=0; the new block pairs (0,16) with tf=0.
- Misalignment: the stub provider drops tf_in_valid once during Phase B -> align_err rises 1 cycle after the affected s1 cycle and stays high until rst.
- Reset values: hold rst for 3 cycles with data_in_valid=1 -> tf_en, pair_valid and align_err are 0 throughout.

Source files
------------

// File: rtl/sdf_pair_aligner5_pkg.sv
// Shared FFT pipeline definitions: float and complex widths, stage-5 span
// constants, the sequencer phase encoding and the re/im slice helpers.
package sdf_pair_aligner5_pkg;

  localparam int FLOAT_LEN        = 32;
  localparam int CPLX_LEN         = 2 * FLOAT_LEN;
  localparam int HALF_LEN_S5      = 16;
  localparam int HALF_ADDR_LEN_S5 = 4;

  typedef logic [CPLX_LEN-1:0] cplx_t;

  // Block phase, taken directly from the sample counter MSB.
  typedef enum logic {
    PHASE_A = 1'b0,
    PHASE_B = 1'b1
  } phase_t;

  function automatic logic [FLOAT_LEN-1:0] cplx_re(input cplx_t w);
    return w[CPLX_LEN-1 -: FLOAT_LEN];
  endfunction

  function automatic logic [FLOAT_LEN-1:0] cplx_im(input cplx_t w);
    return w[FLOAT_LEN-1:0];
  endfunction

endpackage

// File: rtl/sdf_pair_aligner5_half_buffer.sv
// First-half sample store: depth x width registers, one synchronous write
// port and one asynchronous read port. Contents are not reset.
module sdf_half_buffer #(
  parameter int width    = 64,
  parameter int depth    = 16,
  parameter int addr_len = 4
) (
  input  logic                clk,
  input  logic                wr_en,
  input  logic [addr_len-1:0] wr_addr,
  input  logic [width-1:0]    wr_data,
  input  logic [addr_len-1:0] rd_addr,
  output logic [width-1:0]    rd_data
);

  logic [width-1:0] mem [depth];

  // Capture a Phase-A sample into its slot.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sdf_pair_aligner5.sv
// Stage-5 SDF input sequencer: buffers the first half of each 2*D block,
// pairs sample n with sample n+D, enables the twiddle provider and emits
// {x1, x2, tf} aligned on pair_valid.
module sdf_pair_aligner5
  import sdf_pair_aligner5_pkg::*;
#(
  parameter int float_len     = FLOAT_LEN,
  parameter int half_len      = HALF_LEN_S5,
  parameter int half_addr_len = HALF_ADDR_LEN_S5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [2*float_len-1:0] data_in,
  input  logic                   data_in_valid,
  output logic                   tf_en,
  input  logic [2*float_len-1:0] tf_in,
  input  logic                   tf_in_valid,
  output logic [2*float_len-1:0] x1_out,
  output logic [2*float_len-1:0] x2_out,
  output logic [2*float_len-1:0] tf_out,
  output logic                   pair_valid,
  output logic                   align_err
);

  localparam int W = 2 * float_len;

  logic [half_addr_len:0]   cnt;
  logic [half_addr_len-1:0] idx;
  phase_t                   phase;
  logic                     wr_en;
  logic [W-1:0]             buf_rd;

  logic                     s1_valid;
  logic [W-1:0]             s1_x1;
  logic [W-1:0]             s1_x2;

  assign idx   = cnt[half_addr_len-1:0];
  assign phase = phase_t'(cnt[half_addr_len]);
  assign wr_en = data_in_valid && (phase == PHASE_A);
  assign tf_en = data_in_valid && (phase == PHASE_B);

  sdf_half_buffer #(
    .width    (W),
    .depth    (half_len),
    .addr_len (half_addr_len)
  ) u_buf (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (idx),
    .wr_data (data_in),
    .rd_addr (idx),
    .rd_data (buf_rd)
  );

  // Sample counter: advances on valid input only, wraps naturally at 2*D.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (data_in_valid) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Stage 1: pair the buffered sample with the live Phase-B sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_x1    <= '0;
      s1_x2    <= '0;
    end else begin
      s1_valid <= tf_en;
      if (tf_en) begin
        s1_x1 <= buf_rd;
        s1_x2 <= data_in;
      end
    end
  end

  // Stage 2: join the pair with the provider's twiddle, which arrives now.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pair_valid <= 1'b0;
      x1_out     <= '0;
      x2_out     <= '0;
      tf_out     <= '0;
    end else begin
      pair_valid <= s1_valid;
      if (s1_valid) begin
        x1_out <= s1_x1;
        x2_out <= s1_x2;
        tf_out <= tf_in;
      end
    end
  end

  // Sticky flag for any cycle where pair and twiddle streams disagree.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      align_err <= 1'b0;
    end else if (s1_valid != tf_in_valid) begin
      align_err <= 1'b1;
    end
  end

endmodule
